// File: rtl/flags_pkg.sv
// Shared types for the NZCV flag unit: op codes, condition codes, flag word
// and the branch-condition evaluator.
package flags_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_ADD   = 4'd1,
        OP_ADC   = 4'd2,
        OP_SUB   = 4'd3,
        OP_SBC   = 4'd4,
        OP_CMP   = 4'd5,
        OP_LOGIC = 4'd6,
        OP_SHIFT = 4'd7,
        OP_WRITE = 4'd8
    } flag_op_t;

    typedef enum logic [3:0] {
        CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
        CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
        CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
        CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15
    } cond_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic cond_eval(flags_t f, cond_t cc);
        case (cc)
            CC_EQ:   return f.z;
            CC_NE:   return !f.z;
            CC_CS:   return f.c;
            CC_CC:   return !f.c;
            CC_MI:   return f.n;
            CC_PL:   return !f.n;
            CC_VS:   return f.v;
            CC_VC:   return !f.v;
            CC_HI:   return f.c && !f.z;
            CC_LS:   return !f.c || f.z;
            CC_GE:   return f.n == f.v;
            CC_LT:   return f.n != f.v;
            CC_GT:   return !f.z && (f.n == f.v);
            CC_LE:   return f.z || (f.n != f.v);
            CC_AL:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/flags_unit_if.sv
// Control-unit side bundle of the flag unit: op strobe, operands, stack
// controls, condition select, and the registered flag/stack status.
interface flags_unit_if
    import flags_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = $clog2(STACK_DEPTH + 1)
);
    logic             upd;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             shift_out;
    flags_t           wr_flags;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [3:0]       cond;
    flags_t           flags;
    logic             cond_true;
    logic [PTR_W-1:0] depth;
    logic             stack_ovf;
    logic             stack_unf;
    logic             stack_col;

    modport master (
        output upd, op, a, b, res, shift_out, wr_flags, push, pop, err_clr, cond,
        input  flags, cond_true, depth, stack_ovf, stack_unf, stack_col
    );

    modport slave (
        input  upd, op, a, b, res, shift_out, wr_flags, push, pop, err_clr, cond,
        output flags, cond_true, depth, stack_ovf, stack_unf, stack_col
    );
endinterface

// File: rtl/flags_stack.sv
// LIFO of saved flag words for interrupt entry/return, with sticky
// overflow, underflow and push/pop collision detection.
module flags_stack
    import flags_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    input  flags_t           din,
    output flags_t           top,
    output logic             pop_ok,
    output logic [PTR_W-1:0] depth,
    output logic             ovf,
    output logic             unf,
    output logic             col
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage is rounded up to a power of two so the index needs no range guard.
    flags_t             mem [2**IDX_W];
    logic               full, empty, push_ok;
    logic               ovf_set, unf_set, col_set;
    logic [IDX_W-1:0]   wr_idx, rd_idx;

    assign full    = (depth == PTR_W'(DEPTH));
    assign empty   = (depth == '0);
    assign push_ok = push && !pop && !full;
    assign pop_ok  = pop && !push && !empty;
    assign ovf_set = push && !pop && full;
    assign unf_set = pop && !push && empty;
    assign col_set = push && pop;
    assign wr_idx  = depth[IDX_W-1:0];
    assign rd_idx  = wr_idx - IDX_W'(1);
    assign top     = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_idx] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            col   <= 1'b0;
        end else begin
            if (push_ok)     depth <= depth + PTR_W'(1);
            else if (pop_ok) depth <= depth - PTR_W'(1);
            // A new error in the same cycle as err_clr wins.
            ovf <= ovf_set || (ovf && !err_clr);
            unf <= unf_set || (unf && !err_clr);
            col <= col_set || (col && !err_clr);
        end
    end

endmodule

// File: rtl/flags_unit.sv
// NZCV flag register with true carry arithmetic, save/restore stack and a
// combinational branch-condition output driven from the registered flags.
module flags_unit
    import flags_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    flags_unit_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    flag_op_t         op;
    flags_t           flags_q, nxt, top;
    logic             pop_ok, is_sub, cin;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   s;

    assign op = flag_op_t'(bus.op);

    // Subtraction is done as a + ~b + cin so C reads as "no borrow".
    always_comb begin
        is_sub = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
        b_op   = is_sub ? ~bus.b : bus.b;
        case (op)
            OP_ADC, OP_SBC: cin = flags_q.c;
            OP_SUB, OP_CMP: cin = 1'b1;
            default:        cin = 1'b0;
        endcase
        s = {1'b0, bus.a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        nxt = flags_q;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                nxt.n = bus.res[MSB];
                nxt.z = (bus.res == '0);
                nxt.c = s[WIDTH];
                nxt.v = ((bus.a[MSB] ^ bus.b[MSB]) == is_sub) && (bus.res[MSB] != bus.a[MSB]);
            end
            OP_LOGIC: begin
                nxt.n = bus.res[MSB];
                nxt.z = (bus.res == '0);
            end
            OP_SHIFT: begin
                nxt.n = bus.res[MSB];
                nxt.z = (bus.res == '0);
                nxt.c = bus.shift_out;
            end
            OP_WRITE: nxt = bus.wr_flags;
            default:  nxt = flags_q;
        endcase
    end

    flags_stack #(.DEPTH(STACK_DEPTH), .PTR_W(PTR_W)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.push),
        .pop     (bus.pop),
        .err_clr (bus.err_clr),
        .din     (flags_q),
        .top     (top),
        .pop_ok  (pop_ok),
        .depth   (bus.depth),
        .ovf     (bus.stack_ovf),
        .unf     (bus.stack_unf),
        .col     (bus.stack_col)
    );

    // An effective pop overrides a same-cycle update; an ignored pop does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          flags_q <= '0;
        else if (pop_ok)  flags_q <= top;
        else if (bus.upd) flags_q <= nxt;
    end

    assign bus.flags     = flags_q;
    assign bus.cond_true = cond_eval(flags_q, cond_t'(bus.cond));

endmodule

// File: tb/tb_flags_unit.sv
// Randomized and directed bench for flags_unit against an arithmetic-level
// model of the flags, a queue-based stack and sticky error bits.
module tb_flags_unit;
    localparam int     W     = 12;
    localparam int     SD    = 4;
    localparam int     PW    = $clog2(SD + 1);
    localparam longint MOD   = longint'(1) << W;
    localparam longint HALF  = MOD / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flags_unit_if #(.WIDTH(W), .STACK_DEPTH(SD)) fif ();
    flags_unit #(.WIDTH(W), .STACK_DEPTH(SD)) dut (.clk(clk), .rst(rst), .bus(fif));

    int checks = 0;
    int failures = 0;

    logic [3:0] mf;
    logic [3:0] mq[$];
    bit         movf, munf, mcol;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input int x);
        return (longint'(x) >= HALF) ? longint'(x) - MOD : longint'(x);
    endfunction

    function automatic int alu_res(input int op, input int a, input int b, input bit c);
        longint r;
        case (op)
            1:       r = longint'(a) + b;
            2:       r = longint'(a) + b + c;
            3, 5:    r = longint'(a) - b;
            4:       r = longint'(a) - b - 1 + c;
            default: r = $urandom_range(0, int'(MOD - 1));
        endcase
        return int'(((r % MOD) + MOD) % MOD);
    endfunction

    function automatic logic [3:0] op_ref(input int op, input int a, input int b, input int res,
                                          input bit sh, input logic [3:0] wr, input logic [3:0] cur);
        bit n = cur[3], z = cur[2], c = cur[1], v = cur[0];
        longint u, s, cin;
        if (op >= 1 && op <= 7) begin
            n = (longint'(res) >= HALF);
            z = (res == 0);
        end
        case (op)
            1, 2: begin
                cin = (op == 2) ? longint'(c) : 0;
                u = longint'(a) + b + cin;
                s = sx(a) + sx(b) + cin;
                c = (u >= MOD);
                v = (s >= HALF) || (s < -HALF);
            end
            3, 4, 5: begin
                cin = (op == 4) ? longint'(c) : 1;
                u = longint'(a) - b - 1 + cin;
                s = sx(a) - sx(b) - 1 + cin;
                c = (u >= 0);
                v = (s >= HALF) || (s < -HALF);
            end
            7: c = sh;
            8: return wr;
            default: ;
        endcase
        return {n, z, c, v};
    endfunction

    function automatic bit cond_ref(input logic [3:0] f, input logic [3:0] cc);
        bit n = f[3], z = f[2], c = f[1], v = f[0];
        bit r;
        case (cc[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c & ~z;
            3'd5: r = ~(n ^ v);
            3'd6: r = ~z & ~(n ^ v);
            default: r = 1'b1;
        endcase
        return cc[0] ? ~r : r;
    endfunction

    task automatic model_step();
        bit pu = fif.push, po = fif.pop;
        bit pop_eff  = po && !pu && (mq.size() > 0);
        bit push_eff = pu && !po && (mq.size() < SD);
        logic [3:0] nf = mf;
        if (fif.upd) nf = op_ref(int'(fif.op), int'(fif.a), int'(fif.b), int'(fif.res),
                                 fif.shift_out, fif.wr_flags, mf);
        movf = (pu && !po && mq.size() == SD) || (movf && !fif.err_clr);
        munf = (po && !pu && mq.size() == 0) || (munf && !fif.err_clr);
        mcol = (pu && po) || (mcol && !fif.err_clr);
        if (push_eff) mq.push_back(mf);
        if (pop_eff) nf = mq.pop_back();
        mf = nf;
    endtask

    task automatic model_reset();
        mf = 4'h0;
        mq.delete();
        movf = 0; munf = 0; mcol = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_flags"}, 32'(fif.flags), 32'(mf));
        chk({tag, "_depth"}, 32'(fif.depth), 32'(mq.size()));
        chk({tag, "_ovf"}, 32'(fif.stack_ovf), 32'(movf));
        chk({tag, "_unf"}, 32'(fif.stack_unf), 32'(munf));
        chk({tag, "_col"}, 32'(fif.stack_col), 32'(mcol));
        chk({tag, "_cond"}, 32'(fif.cond_true), 32'(cond_ref(mf, fif.cond)));
    endtask

    task automatic set_in(input bit upd, input int op, input int a, input int b, input int res,
                          input logic [3:0] wr, input bit push, input bit pop, input bit clr);
        fif.upd = upd; fif.op = 4'(op); fif.a = W'(a); fif.b = W'(b); fif.res = W'(res);
        fif.shift_out = 1'b0; fif.wr_flags = wr; fif.push = push; fif.pop = pop;
        fif.err_clr = clr;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        set_in(0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    endtask

    task automatic cond_chk(input string tag, input int cc, input bit exp);
        fif.cond = 4'(cc);
        #1;
        chk(tag, 32'(fif.cond_true), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        fif.cond = 4'd0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: ADD overflow into sign bit
        set_in(1, 1, 'h7FF, 'h001, 'h800, 4'h0, 0, 0, 0); step("tp1");
        chk("tp1_nzcv", 32'(fif.flags), 32'h9);
        cond_chk("tp1_vs", 6, 1'b1);

        // 2: SUB equal, then SUB with borrow
        set_in(1, 3, 'h005, 'h005, 'h000, 4'h0, 0, 0, 0); step("tp2a");
        chk("tp2a_nzcv", 32'(fif.flags), 32'h6);
        set_in(1, 3, 'h003, 'h005, 'hFFE, 4'h0, 0, 0, 0); step("tp2b");
        chk("tp2b_nzcv", 32'(fif.flags), 32'h8);
        cond_chk("tp2_lt", 11, 1'b1);
        cond_chk("tp2_cc", 3, 1'b1);
        cond_chk("tp2_hi", 8, 1'b0);

        // 3: ADC with carry-in, then LOGIC keeps C and V
        set_in(1, 8, 0, 0, 0, 4'b0010, 0, 0, 0); step("tp3w");
        set_in(1, 2, 'hFFF, 'h000, 'h000, 4'h0, 0, 0, 0); step("tp3a");
        chk("tp3a_nzcv", 32'(fif.flags), 32'h6);
        set_in(1, 6, 0, 0, 'h400, 4'h0, 0, 0, 0); step("tp3b");
        chk("tp3b_nzcv", 32'(fif.flags), 32'h2);

        // 4: stack fill, overflow, LIFO drain, underflow
        set_in(1, 8, 0, 0, 0, 4'b1010, 0, 0, 0); step("tp4w1");
        set_in(0, 0, 0, 0, 0, 4'h0, 1, 0, 0); step("tp4p1");
        set_in(1, 8, 0, 0, 0, 4'b0101, 0, 0, 0); step("tp4w2");
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 4'h0, 1, 0, 0); step("tp4push");
        end
        chk("tp4_ovf", 32'(fif.stack_ovf), 32'h1);
        chk("tp4_depth", 32'(fif.depth), 32'h4);
        set_in(1, 8, 0, 0, 0, 4'b0000, 0, 0, 1); step("tp4clr");
        set_in(0, 0, 0, 0, 0, 4'h0, 0, 1, 0); step("tp4pop1");
        chk("tp4_pop1", 32'(fif.flags), 32'h5);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 4'h0, 0, 1, 0); step("tp4pop");
        end
        chk("tp4_poplast", 32'(fif.flags), 32'hA);
        set_in(0, 0, 0, 0, 0, 4'h0, 0, 1, 0); step("tp4unf");
        chk("tp4_unf", 32'(fif.stack_unf), 32'h1);

        // 5: push+upd saves old flags; push+pop collides; err_clr
        set_in(1, 8, 0, 0, 0, 4'b1111, 0, 0, 1); step("tp5w");
        set_in(1, 1, 'h001, 'h001, 'h002, 4'h0, 1, 0, 0); step("tp5pu");
        chk("tp5_new", 32'(fif.flags), 32'h0);
        set_in(0, 0, 0, 0, 0, 4'h0, 1, 1, 0); step("tp5col");
        chk("tp5_col", 32'(fif.stack_col), 32'h1);
        chk("tp5_depth", 32'(fif.depth), 32'h1);
        set_in(0, 0, 0, 0, 0, 4'h0, 0, 1, 1); step("tp5pop");
        chk("tp5_saved", 32'(fif.flags), 32'hF);
        chk("tp5_clr", 32'({fif.stack_ovf, fif.stack_unf, fif.stack_col}), 32'h0);

        // 6: asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 4'h0, 1, 0, 0); step("tp6push");
        end
        set_in(1, 8, 0, 0, 0, 4'b1111, 0, 0, 0); step("tp6w");
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("tp6_flags", 32'(fif.flags), 32'h0);
        chk("tp6_depth", 32'(fif.depth), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 4'h0, 1, 0, 0); step("tp6after");
        chk("tp6_push", 32'(fif.depth), 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int op = $urandom_range(0, 15);
            int a  = $urandom_range(0, int'(MOD - 1));
            int b  = $urandom_range(0, int'(MOD - 1));
            if ($urandom_range(0, 7) == 0) a = int'(HALF) - 1;
            set_in($urandom_range(0, 9) < 6, op, a, b, alu_res(op, a, b, mf[1]),
                   4'($urandom_range(0, 15)), $urandom_range(0, 5) == 0,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
            fif.shift_out = 1'($urandom_range(0, 1));
            fif.cond = 4'($urandom_range(0, 15));
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
